// File: rtl/edge_sched_pkg.sv
// Shared types for the edge event scheduler.
// Edge-mode encodings and output FSM state.
package edge_sched_pkg;

  typedef enum logic [1:0] {
    EDGE_POS  = 2'd0,
    EDGE_NEG  = 2'd1,
    EDGE_BOTH = 2'd2,
    EDGE_OFF  = 2'd3
  } edge_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/edge_sample_tick.sv
// Sample prescaler: one-cycle Tick every Divider+1 clocks.
// Tick is registered so it is low during and right after reset.
module edge_sample_tick #(
  parameter int DIVW = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [DIVW-1:0] Divider,
  output logic            Tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q >= Divider);
    cnt_d  = tick_d ? '0 : cnt_q + DIVW'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel edge detector with pending/overflow tracking
// and a round-robin valid/ready event presenter.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 3,
  parameter int UPWIDTH  = 2,
  parameter int DIVW     = 16
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [CHANNELS-1:0]         In,
  input  logic [2*CHANNELS-1:0]       EdgeType,
  input  logic [DIVW-1:0]             Divider,
  output logic                        Tick,
  output logic                        EventValid,
  input  logic                        EventReady,
  output logic [$clog2(CHANNELS)-1:0] EventChannel,
  output logic                        EventRising,
  output logic [CHANNELS-1:0]         Overflow,
  input  logic                        OverflowClear
);

  localparam int CW = $clog2(CHANNELS);

  logic tick;
  logic tick_dly_q;

  logic [CHANNELS-1:0][WIDTH-1:0] sh_q, sh_d;
  logic [CHANNELS-1:0] rise_v, fall_v, det, det_rise;
  logic [CHANNELS-1:0] pend_q, pend_d, pol_q, pol_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  sched_state_e state_q, state_d;
  logic [CW-1:0] chan_q, chan_d, last_q, last_d, win;
  logic          rise_q, rise_d, found, accept;

  edge_sample_tick #(.DIVW(DIVW)) u_tick (
    .Clock   (Clock),
    .Reset   (Reset),
    .Divider (Divider),
    .Tick    (tick)
  );

  always_comb begin
    sh_d = sh_q;
    if (tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sh_d[c] = {sh_q[c][WIDTH-2:0], In[c]};
      end
    end
  end

  // Patterns only match once per edge, so one edge -> one detect.
  always_comb begin
    rise_v   = '0;
    fall_v   = '0;
    det      = '0;
    det_rise = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rise_v[c] = (sh_q[c][WIDTH-1:UPWIDTH] == '0) &&
                  (sh_q[c][UPWIDTH-1:0] == '1);
      fall_v[c] = (sh_q[c][WIDTH-1:UPWIDTH] == '1) &&
                  (sh_q[c][UPWIDTH-1:0] == '0);
      case (edge_type_e'(EdgeType[2*c +: 2]))
        EDGE_POS:  det[c] = rise_v[c];
        EDGE_NEG:  det[c] = fall_v[c];
        EDGE_BOTH: det[c] = rise_v[c] | fall_v[c];
        default:   det[c] = 1'b0;
      endcase
      det[c]      = det[c] & tick_dly_q;
      det_rise[c] = rise_v[c];
    end
  end

  assign accept = (state_q == ST_PRESENT) && EventReady;

  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    ovf_d  = OverflowClear ? '0 : ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (det[c]) begin
        if (pend_q[c] && !(accept && chan_q == CW'(c))) begin
          ovf_d[c] = 1'b1;
        end else begin
          pend_d[c] = 1'b1;
          pol_d[c]  = det_rise[c];
        end
      end else if (accept && chan_q == CW'(c)) begin
        pend_d[c] = 1'b0;
      end
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      int idx;
      idx = (int'(last_q) + i) % CHANNELS;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    rise_d  = rise_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          chan_d  = win;
          rise_d  = pol_q[win];
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (EventReady) begin
          last_d  = chan_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tick_dly_q <= 1'b0;
      sh_q       <= '0;
      pend_q     <= '0;
      pol_q      <= '0;
      ovf_q      <= '0;
      state_q    <= ST_IDLE;
      chan_q     <= '0;
      rise_q     <= 1'b0;
      last_q     <= CW'(CHANNELS - 1);
    end else begin
      tick_dly_q <= tick;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pol_q      <= pol_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      chan_q     <= chan_d;
      rise_q     <= rise_d;
      last_q     <= last_d;
    end
  end

  assign Tick         = tick;
  assign EventValid   = (state_q == ST_PRESENT);
  assign EventChannel = chan_q;
  assign EventRising  = rise_q;
  assign Overflow     = ovf_q;

endmodule

// File: doc/edge_event_scheduler.md
EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of monitored inputs (2..16).
REQ-002 SHALL have parameter WIDTH, default 3, samples per channel shift register.
REQ-003 SHALL have parameter UPWIDTH, default 2, consecutive new-level samples required (1..WIDTH-1).
REQ-004 SHALL have parameter DIVW, default 16, prescaler width.
REQ-005 SHALL have port Clock  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port In  input  CHANNELS  raw asynchronous-origin inputs, one per channel.
REQ-008 SHALL have port EdgeType  input  2*CHANNELS  per-channel mode: 0 posedge, 1 negedge, 2 both, 3 disabled.
REQ-009 SHALL have port Divider  input  DIVW  sample period minus one, in Clock cycles.
REQ-010 SHALL have port Tick  output  1  one-cycle sample strobe.
REQ-011 SHALL have port EventValid  output  1  event presented.
REQ-012 SHALL have port EventReady  input  1  consumer accepts event.
REQ-013 SHALL have port EventChannel  output  clog2(CHANNELS)  channel of presented event.
REQ-014 SHALL have port EventRising  output  1  1 = rising edge, 0 = falling.
REQ-015 SHALL have port Overflow  output  CHANNELS  sticky per-channel lost-event flags.
REQ-016 SHALL have port OverflowClear  input  1  clears all Overflow bits.

Function
REQ-017 Prescaler SHALL count 0..Divider, assert Tick for one cycle when count >= Divider, then wrap to 0; Divider=0 gives Tick every cycle; lowering Divider below count wraps on next cycle.
REQ-018 Each channel SHALL shift In into a WIDTH-bit register, newest at bit 0, only on Tick cycles.
REQ-019 Detection SHALL be evaluated only in the cycle after a Tick: rising = upper WIDTH-UPWIDTH bits all 0 and lower UPWIDTH bits all 1; falling = inverse; mode 2 accepts either; mode 3 never detects.
REQ-020 A detect SHALL set the channel pending bit and record polarity; one physical edge SHALL yield exactly one detect.
REQ-021 A detect on an already-pending channel not being accepted that cycle SHALL set Overflow for that channel and keep the original polarity.
REQ-022 A detect in the same cycle its channel is accepted SHALL leave pending set with new polarity and no Overflow.
REQ-023 Output FSM SHALL have states IDLE and PRESENT: IDLE with any pending -> load round-robin winner (search from last granted + 1) into EventChannel/EventRising, go PRESENT; PRESENT drives EventValid=1.
REQ-024 In PRESENT, EventChannel/EventRising SHALL stay stable until EventValid and EventReady; that cycle clears winner pending, updates last-granted, returns to IDLE.
REQ-025 Latency: detect cycle to EventValid SHALL be 2 cycles when IDLE; maximum throughput one event per 2 cycles.
REQ-026 OverflowClear SHALL clear all Overflow bits; a same-cycle overflow set SHALL win for its channel.
REQ-027 EdgeType changes SHALL not alter already-pending events.

Reset
REQ-028 Reset low SHALL immediately force: prescaler 0, Tick 0, shift registers 0, pending 0, Overflow 0, EventValid 0, EventChannel 0, EventRising 0, FSM IDLE, last-granted CHANNELS-1.
REQ-029 Reset asserted in PRESENT SHALL drop the event without handshake; first Tick after release SHALL occur Divider+1 cycles later.

Structure
REQ-030 Package edge_sched_pkg SHALL hold edge-type encodings and the FSM state type.
REQ-031 Prescaler SHALL be sub-module edge_sample_tick (Clock, Reset, Divider, Tick).

Verification
REQ-032 Divider=3, In[0] 0->1 held, EdgeType[0]=0 -> Tick every 4 cycles; exactly one event ch0 rising, after second post-edge Tick.
REQ-033 In[1] pulse shorter than one sample period, UPWIDTH=2 -> no event.
REQ-034 Ch0, ch2 detect same cycle, EventReady=1 -> ch0 then ch2, next round starts ch3.
REQ-035 EventReady=0, ch1 two edges (mode 2) -> one event rising, Overflow[1]=1; OverflowClear -> Overflow[1]=0.
REQ-036 Reset low during PRESENT -> EventValid=0 same cycle, pending 0 after release.
REQ-037 Divider=0, ch3 mode 3 toggling -> Tick every cycle, no ch3 events.
